// File: rtl/cfar_threshold_gen_pkg.sv
// Shared window geometry and width helpers for the CA-CFAR threshold generator.
// Parameterised localparams are derived in each module through these functions.
package cfar_threshold_gen_pkg;

  localparam int ALPHA_W = 4;

  function automatic int log2c(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int win_len(input int nref, input int nguard);
    return 2 * nref + 2 * nguard + 1;
  endfunction

  function automatic int cut_idx(input int nref, input int nguard);
    return nref + nguard;
  endfunction

  function automatic int sum_wl(input int il, input int nref);
    return il + log2c(nref);
  endfunction

  function automatic int sat_max(input int il);
    return (1 << il) - 1;
  endfunction

endpackage

// File: rtl/D_FF_enable.sv
// Enabled D flip-flop with asynchronous active-low clear.
module D_FF_enable #(
  parameter int WL = 1
) (
  input  logic          iCLK,
  input  logic          iRSTn,
  input  logic          iEN,
  input  logic [WL-1:0] iD,
  output logic [WL-1:0] oQ
);

  logic [WL-1:0] q_q;
  logic [WL-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (iEN) q_d = iD;
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) q_q <= '0;
    else        q_q <= q_d;
  end

  assign oQ = q_q;

endmodule

// File: rtl/cfar_ref_window.sv
// Sliding sample window with incrementally maintained lead/lag reference sums,
// a saturating fill counter, and the stage-1 valid flag.
module cfar_ref_window
  import cfar_threshold_gen_pkg::*;
#(
  parameter  int IL     = 10,
  parameter  int NREF   = 4,
  parameter  int NGUARD = 1,
  localparam int SUM_WL = sum_wl(IL, NREF)
) (
  input  logic              iCLK,
  input  logic              iRSTn,
  input  logic              iEN,
  input  logic [IL-1:0]     iDATA,
  output logic [IL-1:0]     oCUT,
  output logic [SUM_WL-1:0] oLEAD,
  output logic [SUM_WL-1:0] oLAG,
  output logic              oV1
);

  localparam int W       = win_len(NREF, NGUARD);
  localparam int CUT_IDX = cut_idx(NREF, NGUARD);
  localparam int LAG_IN  = NREF + 2 * NGUARD;
  localparam int FILL_W  = $clog2(W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(W);

  logic [IL-1:0]     sr_q [W];
  logic [IL-1:0]     sr_d [W];
  logic [SUM_WL-1:0] lead_q, lead_d;
  logic [SUM_WL-1:0] lag_q, lag_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              v1_q, v1_d;

  // Sums use pre-shift taps: the sample entering each side minus the one leaving it.
  always_comb begin
    sr_d   = sr_q;
    lead_d = lead_q;
    lag_d  = lag_q;
    fill_d = fill_q;
    v1_d   = 1'b0;
    if (iEN) begin
      for (int i = W - 1; i > 0; i--) sr_d[i] = sr_q[i-1];
      sr_d[0] = iDATA;
      lead_d  = lead_q + SUM_WL'(iDATA) - SUM_WL'(sr_q[NREF-1]);
      lag_d   = lag_q + SUM_WL'(sr_q[LAG_IN]) - SUM_WL'(sr_q[W-1]);
      fill_d  = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
      v1_d    = (fill_d == FILL_FULL);
    end
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      for (int i = 0; i < W; i++) sr_q[i] <= '0;
      lead_q <= '0;
      lag_q  <= '0;
      fill_q <= '0;
      v1_q   <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      lead_q <= lead_d;
      lag_q  <= lag_d;
      fill_q <= fill_d;
      v1_q   <= v1_d;
    end
  end

  assign oCUT  = sr_q[CUT_IDX];
  assign oLEAD = lead_q;
  assign oLAG  = lag_q;
  assign oV1   = v1_q;

endmodule

// File: rtl/cfar_threshold_gen.sv
// Cell-averaging CFAR threshold generator: window/sums in stage 1, scaled and
// saturated threshold registered with the aligned CUT in stage 2.
module cfar_threshold_gen
  import cfar_threshold_gen_pkg::*;
#(
  parameter int IL        = 10,
  parameter int NREF      = 4,
  parameter int NGUARD    = 1,
  parameter int ALPHA_NUM = 3,
  parameter int ALPHA_SH  = 1
) (
  input  logic          iCLK,
  input  logic          iRSTn,
  input  logic          iEN,
  input  logic [IL-1:0] iDATA,
  output logic [IL-1:0] oDATA,
  output logic [IL-1:0] oTH,
  output logic          oEN
);

  localparam int SUM_WL = sum_wl(IL, NREF);
  localparam int AVG_SH = log2c(2 * NREF);
  localparam int MUL_W  = IL + ALPHA_W;
  localparam logic [ALPHA_W-1:0] ALPHA_U = ALPHA_W'(ALPHA_NUM);
  localparam logic [MUL_W-1:0]   SAT_LIM = MUL_W'(sat_max(IL));

  function automatic logic [IL-1:0] sat_il(input logic [MUL_W-1:0] v);
    return (v > SAT_LIM) ? {IL{1'b1}} : v[IL-1:0];
  endfunction

  logic [IL-1:0]     cut_p1;
  logic [SUM_WL-1:0] lead_p1, lag_p1;
  logic              vld_p1;
  logic [SUM_WL:0]   sum_p1;
  logic [IL-1:0]     avg_p1;
  logic [MUL_W-1:0]  prod_p1;
  logic [IL-1:0]     th_p1;

  cfar_ref_window #(
    .IL     (IL),
    .NREF   (NREF),
    .NGUARD (NGUARD)
  ) u_window (
    .iCLK  (iCLK),
    .iRSTn (iRSTn),
    .iEN   (iEN),
    .iDATA (iDATA),
    .oCUT  (cut_p1),
    .oLEAD (lead_p1),
    .oLAG  (lag_p1),
    .oV1   (vld_p1)
  );

  // Stage 1 -> 2: average over 2*NREF cells, scale by ALPHA_NUM/2^ALPHA_SH, clamp.
  always_comb begin
    sum_p1  = {1'b0, lead_p1} + {1'b0, lag_p1};
    avg_p1  = IL'(sum_p1 >> AVG_SH);
    prod_p1 = MUL_W'(avg_p1) * MUL_W'(ALPHA_U);
    th_p1   = sat_il(prod_p1 >> ALPHA_SH);
  end

  D_FF_enable #(.WL(IL)) u_data_p2 (
    .iCLK  (iCLK),
    .iRSTn (iRSTn),
    .iEN   (vld_p1),
    .iD    (cut_p1),
    .oQ    (oDATA)
  );

  D_FF_enable #(.WL(IL)) u_th_p2 (
    .iCLK  (iCLK),
    .iRSTn (iRSTn),
    .iEN   (vld_p1),
    .iD    (th_p1),
    .oQ    (oTH)
  );

  D_FF_enable #(.WL(1)) u_en_p2 (
    .iCLK  (iCLK),
    .iRSTn (iRSTn),
    .iEN   (1'b1),
    .iD    (vld_p1),
    .oQ    (oEN)
  );

endmodule

// File: doc/cfar_threshold_gen.md
Name: cfar_threshold_gen

Overview:
- Cell-averaging CFAR threshold generator. Produces the per-cell data/threshold pair consumed by the downstream 1-bit threshold comparator (its iDATA/iTH/iEN inputs).
- Takes the STFT magnitude stream and holds a sliding window of reference, guard and cell-under-test (CUT) samples.
- Outputs the delayed CUT plus a scaled reference-cell average, aligned, with a one-cycle valid strobe per accepted sample.
- Sits between the magnitude stage and the comparator in the radar detection path.

Parameters:
- IL, 10, sample and threshold width (bits).
- NREF, 4, reference cells per side. Must be a power of two, at least 1.
- NGUARD, 1, guard cells per side. At least 0.
- ALPHA_NUM, 3, threshold scale numerator. Unsigned, 4 bits.
- ALPHA_SH, 1, threshold scale right-shift (scale = ALPHA_NUM / 2^ALPHA_SH).

Ports:
- iCLK  in  1  clock; all state changes on the rising edge.
- iRSTn  in  1  asynchronous active-low reset.
- iEN  in  1  input sample valid; one sample accepted per cycle it is high.
- iDATA  in  IL  unsigned magnitude sample.
- oDATA  out  IL  CUT sample, aligned with oTH.
- oTH  out  IL  CFAR threshold for oDATA.
- oEN  out  1  output valid, one cycle per produced pair.

Behaviour:
- Window length W = 2*NREF + 2*NGUARD + 1. Shift register sr[0..W-1]; sr[0] is the newest sample.
  - Lead window: sr[0..NREF-1].
  - CUT: sr[NREF+NGUARD].
  - Lag window: sr[NREF+2*NGUARD+1..W-1].
- Stage 1, edge with iEN=1:
  - sr shifts by one and iDATA enters sr[0].
  - Running sums update incrementally from pre-shift values:
    - LEAD += iDATA − sr[NREF−1]
    - LAG += sr[NREF+2*NGUARD] − sr[W−1]
  - Sums are unsigned, width IL+log2(NREF). They never go negative.
  - fill counter increments, saturating at W.
  - v1 <= 1 if fill reaches W on this edge; otherwise v1 <= 0.
- Stage 1, edge with iEN=0: sr, sums and fill hold; v1 <= 0.
- Stage 2, every edge:
  - oEN <= v1.
  - If v1=1: oDATA <= sr[NREF+NGUARD]; oTH <= sat_IL(((LEAD+LAG) >> log2(2*NREF)) * ALPHA_NUM >> ALPHA_SH).
  - If v1=0: oDATA and oTH hold.
- Latency: oEN goes high exactly 2 cycles after the iEN edge that made the window full, and after every later iEN.
- Throughput: one output per accepted input. oEN is never high for two cycles unless iEN was high for two consecutive cycles.
- Saturation: any threshold ≥ 2^IL clamps to 2^IL−1. Multiplier width is IL+4.
- Warm-up: the first W−1 accepted samples produce no oEN. The first output's CUT is the (NREF+NGUARD+1)-th sample accepted.
- iEN gaps: no effect on the output sequence except the delay. Outputs hold between oEN pulses.
- Reset (any time, including mid-stream): sr, LEAD, LAG, fill, v1, oDATA, oTH and oEN all clear to 0 immediately. A full W-sample warm-up is required again.
- No edge handling at frame boundaries. The window slides continuously across frames, and framing is the upstream block's concern.

Decomposition:
- Shared header (localparams):
  - W computed from NREF/NGUARD.
  - CUT_IDX.
  - SUM_WL = IL + log2(NREF).
  - Saturation constant.
- Sub-module cfar_ref_window: shift register plus the LEAD/LAG incremental sums and the fill counter. Outputs the CUT, both sums, and v1.
- Top level holds the scaling, saturation and output registers.
- Output registers reuse the existing D_FF_enable (WL=IL for data/threshold, WL=1 for oEN).

Test Plan (IL=10, NREF=4, NGUARD=1, W=11, ALPHA 3/2^1):
- Constant 100, iEN=1 continuously: no oEN for samples 1–10. After sample 11, oEN rises 2 cycles later, with oDATA=100 and oTH=150 (avg 100, ×1.5), then oEN stays high every cycle.
- Single spike 800 in a constant-100 stream:
  - Spike as CUT → oDATA=800, oTH=150.
  - Spike in a guard cell → oDATA=100, oTH=150.
  - Spike in any reference cell → avg=(700+800)>>3=187, oTH=280.
- All samples 1023: raw threshold 1534 saturates, so oTH=1023 and oDATA=1023.
- Same stream as scenario 1 with iEN=1 only every third cycle: identical oDATA/oTH sequence. Each oEN is a single cycle 2 cycles after its iEN, and outputs hold in between.
- Assert iRSTn=0 after 6 samples of the ramp 1,2,3,…: all outputs 0 asynchronously. After release, a ramp restarted at 1 needs 11 samples. The first output has oDATA=6 and oTH=(1+2+3+4+8+9+10+11)/8=6, ×1.5 → 9.
- Ramp 1..11 then idle: exactly one oEN pulse, 2 cycles after sample 11, with oDATA=6 and oTH=9.
